// File: rtl/argmax_sequencer_if.sv
// Score stream and result handshake between the classifier datapath and
// the argmax sequencer.
interface argmax_sequencer_if #(
  parameter int DATA_W = 26,
  parameter int IDX_W  = 4
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              r_valid;
  logic              r_ready;
  logic [IDX_W-1:0]  r_class;
  logic [DATA_W-1:0] r_score;
  logic              r_err;

  modport master (
    output s_valid, s_data, s_last, r_ready,
    input  s_ready, r_valid, r_class, r_score, r_err
  );

  modport slave (
    input  s_valid, s_data, s_last, r_ready,
    output s_ready, r_valid, r_class, r_score, r_err
  );
endinterface

// File: rtl/argmax_sequencer.sv
// Sequenced argmax over one frame of signed class scores using a single
// comparator, with a held result handshake and framing-error reporting.
module argmax_sequencer #(
  parameter int DATA_W      = 26,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  argmax_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                    state;
  state_t                    state_next;
  logic [IDX_W-1:0]          cnt;
  logic signed [DATA_W-1:0]  max_score;
  logic [IDX_W-1:0]          max_idx;
  logic [IDX_W-1:0]          r_class_q;
  logic [DATA_W-1:0]         r_score_q;
  logic                      r_err_q;

  logic                      beat_acc;
  logic                      is_last_cnt;
  logic                      frame_end;
  logic                      take;
  logic signed [DATA_W-1:0]  cand_score;
  logic [IDX_W-1:0]          cand_idx;

  assign bus.s_ready = (state == COLLECT);
  assign bus.r_valid = (state == DONE);
  assign bus.r_class = r_class_q;
  assign bus.r_score = r_score_q;
  assign bus.r_err   = r_err_q;

  // Beat 0 seeds the running max; later beats win only on a strictly
  // greater score, so ties keep the lower class index.
  assign beat_acc    = bus.s_valid && (state == COLLECT);
  assign is_last_cnt = (cnt == LAST_IDX);
  assign frame_end   = beat_acc && (is_last_cnt || bus.s_last);
  assign take        = (cnt == '0) || ($signed(bus.s_data) > max_score);
  assign cand_score  = take ? $signed(bus.s_data) : max_score;
  assign cand_idx    = take ? cnt : max_idx;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (frame_end) state_next = DONE;
      DONE:    if (bus.r_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // The result registers are loaded with the candidate of the final beat so
  // they present the completed frame one cycle after it is accepted and keep
  // the previous result visible while the next frame is being collected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      max_score <= '0;
      max_idx   <= '0;
      r_class_q <= '1;
      r_score_q <= '0;
      r_err_q   <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      if (!abort) begin
        if (state == IDLE && start) begin
          cnt     <= '0;
          r_err_q <= 1'b0;
        end else if (beat_acc) begin
          cnt       <= cnt + 1'b1;
          max_score <= cand_score;
          max_idx   <= cand_idx;
          if (frame_end) begin
            r_class_q <= cand_idx;
            r_score_q <= cand_score;
            r_err_q   <= !(is_last_cnt && bus.s_last);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_argmax_sequencer.sv
// Self-checking bench for argmax_sequencer: directed and randomized frames
// compared against a plain array-scan argmax model.
module tb_argmax_sequencer;
  localparam int DATA_W = 26;
  localparam int NUM    = 10;
  localparam int IDX_W  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_misses;

  logic signed [DATA_W-1:0] scores [16];
  logic [IDX_W-1:0]         exp_idx;
  logic signed [DATA_W-1:0] exp_score;
  logic                     exp_err;

  argmax_sequencer_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  argmax_sequencer #(.DATA_W(DATA_W), .NUM_CLASSES(NUM), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: straightforward scan of the first n scores, first maximum wins.
  function automatic void ref_model(input int n, input bit last_flag);
    exp_score = scores[0];
    exp_idx   = '0;
    for (int k = 1; k < n; k++) begin
      if (scores[k] > exp_score) begin
        exp_score = scores[k];
        exp_idx   = IDX_W'(k);
      end
    end
    exp_err = !(n == NUM && last_flag);
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after the final beat.
  task automatic run_frame(input int n, input bit last_flag, input int gap_after, input int gap_len);
    ready_misses = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (bus.s_ready !== 1'b1) ready_misses++;
      bus.s_valid = 1'b1;
      bus.s_data  = scores[k];
      bus.s_last  = (k == n - 1) && last_flag;
      @(negedge clk);
      if (k == gap_after && gap_len > 0) begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = DATA_W'($urandom);
        repeat (gap_len) @(negedge clk);
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic consume();
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.r_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.r_class !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_r_class: got %0d expected 15", bus.r_class); end
    n_checks++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_r_valid: got %0b expected 0", bus.r_valid); end
    n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_s_ready: got %0b expected 0", bus.s_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (bus.r_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_r_err: got %0b expected 0", bus.r_err); end
    n_checks++; if (bus.r_score !== '0) begin n_fail++; $display("[TB] FAIL reset_r_score: got %0d expected 0", bus.r_score); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int vals [10] = '{3, -7, 12, 0, 12, -33554432, 5, 11, -1, 2};
    for (int k = 0; k < NUM; k++) scores[k] = DATA_W'(vals[k]);
    run_frame(NUM, 1'b1, -1, 0);
    n_checks++; if (ready_misses !== 0) begin n_fail++; $display("[TB] FAIL basic_s_ready: got %0d beats without ready expected 0", ready_misses); end
    n_checks++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_r_valid: got %0b expected 1", bus.r_valid); end
    n_checks++; if (bus.r_class !== 4'd2) begin n_fail++; $display("[TB] FAIL basic_r_class: got %0d expected 2", bus.r_class); end
    n_checks++; if (bus.r_score !== 26'd12) begin n_fail++; $display("[TB] FAIL basic_r_score: got %0d expected 12", $signed(bus.r_score)); end
    n_checks++; if (bus.r_err !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_r_err: got %0b expected 0", bus.r_err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy_done: got %0b expected 1", busy); end
    consume();
    n_checks++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_release: got %0b expected 0", bus.r_valid); end
    n_checks++; if (bus.r_class !== 4'd2) begin n_fail++; $display("[TB] FAIL basic_keep_class: got %0d expected 2", bus.r_class); end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DATA_W'(k + 100);
      @(negedge clk);
    end
    bus.s_data = DATA_W'(500);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.r_class !== 4'hF) begin n_fail++; $display("[TB] FAIL async_r_class: got %0d expected 15", bus.r_class); end
    n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL async_s_ready: got %0b expected 0", bus.s_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL async_busy: got %0b expected 0", busy); end
    n_checks++; if (bus.r_score !== '0) begin n_fail++; $display("[TB] FAIL async_r_score: got %0d expected 0", bus.r_score); end
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.s_ready !== 1'b0 || bus.r_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_idle: got s_ready=%0b r_valid=%0b expected 0/0", bus.s_ready, bus.r_valid); end
  endtask

  task automatic test_negative_gaps();
    for (int k = 0; k < NUM - 1; k++) scores[k] = -DATA_W'(5 + $urandom_range(0, 100000));
    scores[NUM-1] = -26'sd4;
    run_frame(NUM, 1'b1, 3, 2);
    n_checks++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL neg_r_valid: got %0b expected 1", bus.r_valid); end
    n_checks++; if (bus.r_class !== 4'd9) begin n_fail++; $display("[TB] FAIL neg_r_class: got %0d expected 9", bus.r_class); end
    n_checks++; if ($signed(bus.r_score) !== -26'sd4) begin n_fail++; $display("[TB] FAIL neg_r_score: got %0d expected -4", $signed(bus.r_score)); end
    n_checks++; if (bus.r_err !== 1'b0) begin n_fail++; $display("[TB] FAIL neg_r_err: got %0b expected 0", bus.r_err); end
    consume();
  endtask

  task automatic test_framing();
    for (int k = 0; k < NUM; k++) scores[k] = DATA_W'($urandom_range(0, 2000)) - 26'sd1000;
    ref_model(7, 1'b1);
    run_frame(7, 1'b1, -1, 0);
    n_checks++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL early_r_valid: got %0b expected 1", bus.r_valid); end
    n_checks++; if (bus.r_err !== 1'b1) begin n_fail++; $display("[TB] FAIL early_r_err: got %0b expected 1", bus.r_err); end
    n_checks++; if (bus.r_class !== exp_idx) begin n_fail++; $display("[TB] FAIL early_r_class: got %0d expected %0d", bus.r_class, exp_idx); end
    n_checks++; if ($signed(bus.r_score) !== exp_score) begin n_fail++; $display("[TB] FAIL early_r_score: got %0d expected %0d", $signed(bus.r_score), exp_score); end
    consume();
    for (int k = 0; k < NUM; k++) scores[k] = DATA_W'($urandom);
    ref_model(NUM, 1'b0);
    run_frame(NUM, 1'b0, -1, 0);
    n_checks++; if (bus.r_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL nolast_r_valid: got %0b expected 1", bus.r_valid); end
    n_checks++; if (bus.r_err !== 1'b1) begin n_fail++; $display("[TB] FAIL nolast_r_err: got %0b expected 1", bus.r_err); end
    n_checks++; if (bus.r_class !== exp_idx) begin n_fail++; $display("[TB] FAIL nolast_r_class: got %0d expected %0d", bus.r_class, exp_idx); end
    n_checks++; if ($signed(bus.r_score) !== exp_score) begin n_fail++; $display("[TB] FAIL nolast_r_score: got %0d expected %0d", $signed(bus.r_score), exp_score); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [IDX_W-1:0]         held_idx;
    logic signed [DATA_W-1:0] held_score;
    for (int k = 0; k < NUM; k++) scores[k] = DATA_W'($urandom);
    ref_model(NUM, 1'b1);
    held_idx   = exp_idx;
    held_score = exp_score;
    run_frame(NUM, 1'b1, -1, 0);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.r_valid !== 1'b1 || bus.r_class !== held_idx || $signed(bus.r_score) !== held_score)
        begin n_fail++; $display("[TB] FAIL hold_result[%0d]: got v=%0b c=%0d s=%0d expected v=1 c=%0d s=%0d", i, bus.r_valid, bus.r_class, $signed(bus.r_score), held_idx, held_score); end
      n_checks++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_s_ready[%0d]: got %0b expected 0", i, bus.s_ready); end
      start = (i % 2 == 0);
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++; if (bus.r_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_start_ignored: got v=%0b busy=%0b expected 1/1", bus.r_valid, busy); end
    consume();
    for (int k = 0; k < NUM; k++) scores[k] = DATA_W'($urandom_range(0, 7)) - 26'sd4;
    ref_model(NUM, 1'b1);
    run_frame(NUM, 1'b1, -1, 0);
    n_checks++; if (ready_misses !== 0) begin n_fail++; $display("[TB] FAIL b2b_s_ready: got %0d beats without ready expected 0", ready_misses); end
    n_checks++; if (bus.r_class !== exp_idx || $signed(bus.r_score) !== exp_score || bus.r_err !== 1'b0)
      begin n_fail++; $display("[TB] FAIL b2b_result: got c=%0d s=%0d e=%0b expected c=%0d s=%0d e=0", bus.r_class, $signed(bus.r_score), bus.r_err, exp_idx, exp_score); end
    consume();
  endtask

  task automatic test_abort();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DATA_W'(1000 + k);
      bus.s_last  = 1'b0;
      abort = (k == 4);
      @(negedge clk);
    end
    abort = 1'b0;
    bus.s_valid = 1'b0;
    n_checks++; if (bus.r_valid !== 1'b0 || busy !== 1'b0 || bus.s_ready !== 1'b0)
      begin n_fail++; $display("[TB] FAIL abort_collect: got v=%0b busy=%0b rdy=%0b expected 0/0/0", bus.r_valid, busy, bus.s_ready); end
    repeat (3) @(negedge clk);
    n_checks++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_no_result: got %0b expected 0", bus.r_valid); end
    for (int k = 0; k < NUM; k++) scores[k] = DATA_W'($urandom);
    ref_model(NUM, 1'b1);
    run_frame(NUM, 1'b1, -1, 0);
    n_checks++; if (bus.r_valid !== 1'b1 || bus.r_class !== exp_idx || $signed(bus.r_score) !== exp_score || bus.r_err !== 1'b0)
      begin n_fail++; $display("[TB] FAIL abort_next_frame: got v=%0b c=%0d s=%0d e=%0b expected v=1 c=%0d s=%0d e=0", bus.r_valid, bus.r_class, $signed(bus.r_score), bus.r_err, exp_idx, exp_score); end
    abort = 1'b1;
    bus.r_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bus.r_ready = 1'b0;
    n_checks++; if (bus.r_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_done: got v=%0b busy=%0b expected 0/0", bus.r_valid, busy); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int  n;
    bit  last_flag;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < NUM; k++)
        scores[k] = (f % 2 == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 3)) - 26'sd2;
      n = (f % 3 == 0) ? $urandom_range(2, NUM) : NUM;
      last_flag = (n < NUM) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ref_model(n, last_flag);
      run_frame(n, last_flag, $urandom_range(0, n - 1), $urandom_range(0, 2));
      n_checks++; if (bus.r_valid !== 1'b1 || bus.r_class !== exp_idx || $signed(bus.r_score) !== exp_score || bus.r_err !== exp_err)
        begin n_fail++; $display("[TB] FAIL random[%0d]: got v=%0b c=%0d s=%0d e=%0b expected v=1 c=%0d s=%0d e=%0b", f, bus.r_valid, bus.r_class, $signed(bus.r_score), bus.r_err, exp_idx, exp_score, exp_err); end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_async_reset();
    test_negative_gaps();
    test_framing();
    test_back_to_back();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
